// File: rtl/suspend_seq_ctrl.sv
// Fabric-side suspend sequencer: quiesces enabled clients on a suspend
// request, waits for their acks plus a settle delay, then returns SACK.
//
// Ports:
//   CLK, RST     rising-edge clock, synchronous active-high reset
//   SREQ / SACK  suspend request in / suspend acknowledge out
//   CLIENT_EN    client participation mask, latched when leaving IDLE
//   QREQ / QACK  per-client quiesce request out / level acknowledge in
//   SUSPENDED    high while the device is held suspended (ACKD)
//   TIMEOUT_ERR  sticky flag: a drain or release wait timed out
//   ERR_CLR      clears TIMEOUT_ERR; a new timeout in the same cycle wins
module suspend_seq_ctrl #(
    parameter int NUM_CLIENTS = 4,
    parameter int ACK_DELAY   = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SREQ,
    output logic                   SACK,
    input  logic [NUM_CLIENTS-1:0] CLIENT_EN,
    output logic [NUM_CLIENTS-1:0] QREQ,
    input  logic [NUM_CLIENTS-1:0] QACK,
    output logic                   SUSPENDED,
    output logic                   TIMEOUT_ERR,
    input  logic                   ERR_CLR
);

    localparam int MAX_CNT = (TIMEOUT > ACK_DELAY) ? TIMEOUT : ACK_DELAY;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] AD_LAST = CW'(ACK_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_SETTLE,
        S_ACKD,
        S_RELEASE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [CW-1:0]          cnt_inc;
    logic [NUM_CLIENTS-1:0] mask_q;
    logic [NUM_CLIENTS-1:0] mask_d;
    logic                   sreq_q;
    logic                   err_set;
    logic                   all_ack;
    logic                   none_ack;
    logic                   quiescing;

    logic [NUM_CLIENTS-1:0] qreq_d;
    logic                   sack_d;
    logic                   susp_d;
    logic                   err_d;

    // Only clients captured in the mask take part; others are ignored.
    assign all_ack  = ((QACK & mask_q) == mask_q);
    assign none_ack = ((QACK & mask_q) == '0);

    // Counter holds at its top value instead of wrapping; exits use >=.
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        err_set = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (sreq_q) begin
                    state_d = S_DRAIN;
                    mask_d  = CLIENT_EN;
                end
            end

            S_DRAIN: begin
                if (!sreq_q) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (all_ack) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_SETTLE: begin
                if (!sreq_q) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q >= AD_LAST) begin
                    state_d = S_ACKD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_ACKD: begin
                if (!sreq_q) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end

            S_RELEASE: begin
                if (none_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so QREQ appears on the
    // same edge the sequencer enters DRAIN.
    always_comb begin
        quiescing = (state_d == S_DRAIN) ||
                    (state_d == S_SETTLE) ||
                    (state_d == S_ACKD);
        qreq_d    = quiescing ? mask_d : '0;
        susp_d    = (state_d == S_ACKD);
        // SACK follows one cycle into ACKD and drops on the exit edge.
        sack_d    = (state_q == S_ACKD) && (state_d == S_ACKD);
        err_d     = err_set | (TIMEOUT_ERR & ~ERR_CLR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            sreq_q      <= 1'b0;
            QREQ        <= '0;
            SACK        <= 1'b0;
            SUSPENDED   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            sreq_q      <= SREQ;
            QREQ        <= qreq_d;
            SACK        <= sack_d;
            SUSPENDED   <= susp_d;
            TIMEOUT_ERR <= err_d;
        end
    end

endmodule

// File: tb/tb_suspend_seq_ctrl.sv
// Bench for suspend_seq_ctrl: directed table, corner-case sequences and
// randomized traffic checked against a timestamp-based reference model.
module tb_suspend_seq_ctrl;

    localparam int NC = 4;
    localparam int AD = 4;
    localparam int TO = 32;

    logic          clk;
    logic          rst;
    logic          sreq;
    logic          sack;
    logic [NC-1:0] client_en;
    logic [NC-1:0] qreq;
    logic [NC-1:0] qack;
    logic          suspended;
    logic          timeout_err;
    logic          err_clr;

    suspend_seq_ctrl #(
        .NUM_CLIENTS(NC),
        .ACK_DELAY  (AD),
        .TIMEOUT    (TO)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .SREQ       (sreq),
        .SACK       (sack),
        .CLIENT_EN  (client_en),
        .QREQ       (qreq),
        .QACK       (qack),
        .SUSPENDED  (suspended),
        .TIMEOUT_ERR(timeout_err),
        .ERR_CLR    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phases with entry timestamps instead of counters.
    localparam int P_IDLE = 0, P_DRAIN = 1, P_SETTLE = 2;
    localparam int P_ACKD = 3, P_REL = 4;

    int            cyc = 0;
    int            ph = P_IDLE;
    int            ph_start = 0;
    logic          m_sreq_q = 1'b0;
    logic [NC-1:0] m_mask = '0;
    logic [NC-1:0] m_qreq = '0;
    logic          m_sack = 1'b0;
    logic          m_susp = 1'b0;
    logic          m_err = 1'b0;

    task automatic model_step();
        int   prev;
        int   nxt;
        int   k;
        logic set;
        logic allack;
        logic noneack;
        cyc++;
        if (rst) begin
            ph = P_IDLE; ph_start = cyc;
            m_sreq_q = 0; m_mask = '0; m_qreq = '0;
            m_sack = 0; m_susp = 0; m_err = 0;
            return;
        end
        prev    = ph;
        nxt     = ph;
        set     = 0;
        k       = cyc - ph_start;
        allack  = ((qack & m_mask) == m_mask);
        noneack = ((qack & m_mask) == '0);
        case (ph)
            P_IDLE:
                if (m_sreq_q) begin
                    nxt = P_DRAIN;
                    m_mask = client_en;
                end
            P_DRAIN:
                if (!m_sreq_q) nxt = P_REL;
                else if (allack) nxt = P_SETTLE;
                else if (k >= TO) begin
                    nxt = P_SETTLE; set = 1;
                end
            P_SETTLE:
                if (!m_sreq_q) nxt = P_REL;
                else if (k >= AD) nxt = P_ACKD;
            P_ACKD:
                if (!m_sreq_q) nxt = P_REL;
            default:
                if (noneack) nxt = P_IDLE;
                else if (k >= TO) begin
                    nxt = P_IDLE; set = 1;
                end
        endcase
        if (nxt != ph) ph_start = cyc;
        ph       = nxt;
        m_sreq_q = sreq;
        m_qreq   = (ph == P_DRAIN || ph == P_SETTLE || ph == P_ACKD)
                   ? m_mask : '0;
        m_susp   = (ph == P_ACKD);
        m_sack   = (prev == P_ACKD) && (ph == P_ACKD);
        m_err    = set | (m_err & ~err_clr);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // One clock: inputs already set; model steps at the edge, DUT is
    // compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_sack", {31'd0, sack}, {31'd0, m_sack});
        chk("m_qreq", {28'd0, qreq}, {28'd0, m_qreq});
        chk("m_susp", {31'd0, suspended}, {31'd0, m_susp});
        chk("m_err", {31'd0, timeout_err}, {31'd0, m_err});
    endtask

    task automatic reset_dut();
        rst = 1; sreq = 0; qack = '0; err_clr = 0; client_en = '0;
        cycle();
        rst = 0;
    endtask

    typedef struct {
        logic          rst;
        logic          sreq;
        logic [NC-1:0] en;
        logic [NC-1:0] qack;
        logic          clr;
        logic          sack;
        logic [NC-1:0] qreq;
        logic          susp;
        logic          err;
    } vec_t;

    vec_t tbl[16];

    logic          found;
    int            k;
    logic [NC-1:0] stuck;

    initial begin
        rst = 1; sreq = 0; qack = '0; err_clr = 0; client_en = '0;

        // Full suspend/resume; CLIENT_EN drops mid-drain and must not matter.
        tbl[0]  = '{1, 0, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0};
        tbl[1]  = '{0, 1, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0};
        tbl[2]  = '{0, 1, 4'hF, 4'h0, 0, 0, 4'hF, 0, 0};
        tbl[3]  = '{0, 1, 4'h0, 4'h0, 0, 0, 4'hF, 0, 0};
        tbl[4]  = '{0, 1, 4'h0, 4'h0, 0, 0, 4'hF, 0, 0};
        tbl[5]  = '{0, 1, 4'h0, 4'hF, 0, 0, 4'hF, 0, 0};
        tbl[6]  = '{0, 1, 4'h0, 4'hF, 0, 0, 4'hF, 0, 0};
        tbl[7]  = '{0, 1, 4'h0, 4'hF, 0, 0, 4'hF, 0, 0};
        tbl[8]  = '{0, 1, 4'h0, 4'hF, 0, 0, 4'hF, 0, 0};
        tbl[9]  = '{0, 1, 4'hF, 4'hF, 0, 0, 4'hF, 1, 0};
        tbl[10] = '{0, 1, 4'hF, 4'hF, 0, 1, 4'hF, 1, 0};
        tbl[11] = '{0, 0, 4'hF, 4'hF, 0, 1, 4'hF, 1, 0};
        tbl[12] = '{0, 0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0};
        tbl[13] = '{0, 0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0};
        tbl[14] = '{0, 0, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0};
        tbl[15] = '{0, 0, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; sreq = tbl[i].sreq; client_en = tbl[i].en;
            qack = tbl[i].qack; err_clr = tbl[i].clr;
            cycle();
            chk($sformatf("t%0d_sack", i), {31'd0, sack}, {31'd0, tbl[i].sack});
            chk($sformatf("t%0d_qreq", i), {28'd0, qreq}, {28'd0, tbl[i].qreq});
            chk($sformatf("t%0d_susp", i), {31'd0, suspended}, {31'd0, tbl[i].susp});
            chk($sformatf("t%0d_err", i), {31'd0, timeout_err}, {31'd0, tbl[i].err});
        end

        // Partial mask; a masked-off client acking is ignored.
        reset_dut();
        client_en = 4'b0101; sreq = 1; qack = 4'b1000;
        cycle(); cycle();
        chk("s3_qreq", {28'd0, qreq}, 32'h5);
        qack = 4'b1101; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (sack) found = 1;
        end
        chk("s3_sack_seen", {31'd0, found}, 32'd1);
        chk("s3_qreq_mask", {28'd0, qreq}, 32'h5);
        sreq = 0; qack = '0;
        repeat (4) cycle();

        // Stuck client: drain times out after TO cycles, SACK still follows.
        reset_dut();
        client_en = 4'hF; sreq = 1;
        cycle(); cycle();
        qack = 4'b0111; k = 0;
        while (k < 60 && !timeout_err) begin cycle(); k++; end
        chk("s4_to_cycles", k, TO);
        chk("s4_sack_early", {31'd0, sack}, 32'd0);
        k = 0;
        while (k < 20 && !sack) begin cycle(); k++; end
        chk("s4_sack_delay", k, AD + 1);
        err_clr = 1; cycle(); err_clr = 0;
        chk("s4_err_clr", {31'd0, timeout_err}, 32'd0);
        sreq = 0; qack = '0;
        repeat (4) cycle();

        // Abort during settle: SACK must never rise.
        reset_dut();
        client_en = 4'hF; sreq = 1; qack = 4'hF;
        cycle(); cycle(); cycle(); cycle();
        sreq = 0; found = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (sack || suspended) found = 1;
        end
        chk("s5_no_sack", {31'd0, found}, 32'd0);
        chk("s5_qreq", {28'd0, qreq}, 32'd0);
        qack = '0;
        repeat (3) cycle();

        // Reset while suspended, request held: clean restart.
        reset_dut();
        client_en = 4'hF; sreq = 1; qack = 4'hF; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (sack) found = 1;
        end
        chk("s6_ackd", {31'd0, found}, 32'd1);
        rst = 1; cycle(); rst = 0;
        chk("s6_sack", {31'd0, sack}, 32'd0);
        chk("s6_qreq", {28'd0, qreq}, 32'd0);
        chk("s6_susp", {31'd0, suspended}, 32'd0);
        cycle();
        chk("s6_qreq_e1", {28'd0, qreq}, 32'd0);
        cycle();
        chk("s6_qreq_e2", {28'd0, qreq}, 32'hF);

        // Random traffic with simple client behaviour.
        reset_dut();
        stuck = '0;
        for (int n = 0; n < 4000; n++) begin
            if (!sreq && $urandom_range(19) == 0) begin
                sreq = 1;
                for (int i = 0; i < NC; i++)
                    stuck[i] = ($urandom_range(7) == 0);
            end else if (sreq && $urandom_range(39) == 0) begin
                sreq = 0;
                for (int i = 0; i < NC; i++)
                    stuck[i] = ($urandom_range(9) == 0);
            end
            for (int i = 0; i < NC; i++) begin
                if (!stuck[i] && qack[i] != m_qreq[i]
                    && $urandom_range(2) == 0)
                    qack[i] = m_qreq[i];
                else if ($urandom_range(15) == 0)
                    qack[i] = ~qack[i];
            end
            client_en = NC'($urandom);
            err_clr   = ($urandom_range(15) == 0);
            rst       = ($urandom_range(299) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
